bomb_countdown_timer: RTL and testbench
=======================================

Name: bomb_countdown_timer

Overview:
- Produces the two-digit BCD time value (units 0-9, tens 0-5) and the bomb flag that the segment display path consumes.
- Converts clock cycles to one-second ticks with a prescaler and counts down from a loaded value.
- Drives bomb high when the count expires to 00; a defuse input freezes the count first.
- Sits upstream of the display block. Its one, ten and bomb outputs connect directly to that block's inputs of the same names.

Parameters:
- TICK_DIV, 1000: clk cycles per countdown step; legal range is 2 or more.
- START_TEN, 5: tens digit after reset; legal range 0-5.
- START_ONE, 9: units digit after reset; legal range 0-9.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; arms the countdown from IDLE.
- pause  input  1  level; while high in RUN, the prescaler and digits hold.
- defuse  input  1  single-cycle pulse; stops the countdown without explosion.
- load  input  1  single-cycle pulse; loads load_ten/load_one (see rules).
- load_ten  input  3  tens value to load.
- load_one  input  4  units value to load.
- one  output  4  BCD units digit, 0-9.
- ten  output  3  tens digit, 0-5.
- bomb  output  1  high while in EXPLODED.
- running  output  1  high while in RUN.
- defused  output  1  high while in DEFUSED.

Behaviour:
- Reset state (asynchronous): state=IDLE, ten=START_TEN, one=START_ONE, prescaler=0, bomb=0, running=0, defused=0.
- All outputs are registered or decoded from the state register. There are no combinational paths from inputs to outputs.
- States: IDLE, RUN, EXPLODED, DEFUSED.
- IDLE:
  - load: digits take load_ten/load_one on the next edge. Values saturate: load_one>9 gives 9; load_ten>5 gives 5.
  - start: prescaler cleared; go to RUN. If digits are 00, go directly to EXPLODED.
  - load and start together: load takes effect; start is ignored that cycle.
- RUN:
  - With pause=0, the prescaler increments each cycle.
  - When the prescaler equals TICK_DIV-1, it wraps to 0 and the digits decrement on the same edge.
  - Decrement rule: if one>0, then one-1. If one=0, then one=9 and ten-1.
  - If the decrement result is ten=0 and one=0, the state becomes EXPLODED on that same edge. bomb rises in the same cycle the digits show 00.
  - First decrement: exactly TICK_DIV cycles after the start edge, with no pause.
  - With pause=1, the prescaler and digits hold. Pausing does not reset the prescaler.
  - defuse: go to DEFUSED with digits frozen at their current value. defuse has priority over a terminal tick in the same cycle.
  - load and start are ignored in RUN.
- EXPLODED:
  - bomb=1 and digits stay 00. start, defuse and pause are ignored.
  - load: go to IDLE with the saturated loaded digits; bomb returns to 0.
- DEFUSED:
  - defused=1 and digits stay frozen. start, defuse and pause are ignored.
  - load: go to IDLE with the loaded digits; defused returns to 0.
- Reset mid-operation (any state): the reset values apply immediately, and any partial prescaler count is discarded.
- Digits never leave the BCD range. No underflow past 00 is possible, because EXPLODED is entered at 00.

Test Plan (TICK_DIV=4):
- Reset, then start with no other stimulus -> running=1. Digits go 59->58 exactly 4 cycles after the start edge, then decrement every 4 cycles. 50->49 correct (one wraps 0->9, ten 5->4).
- Load ten=0, one=2; start -> 01 after 4 cycles, 00 after 8 cycles. bomb=1 on the same edge as 00; running=0. Later start and defuse pulses leave bomb=1.
- Load ten=7, one=12 -> digits read 5,9. Load ten=0, one=0, then start -> EXPLODED on the next edge; bomb=1.
- From 01 in RUN: pause high for 10 cycles mid-period -> digits and prescaler hold. After pause drops, the remaining cycles of the period complete before 01->00.
- At 01, pulse defuse in the terminal-tick cycle -> DEFUSED, digits stay 01, bomb=0, defused=1. Then load 3,0 -> IDLE with digits 30, defused=0.
- Assert rst asynchronously mid-period in RUN at 42 -> outputs return to 59 and IDLE immediately. The next start shows a full 4-cycle first period.

Source files
------------

// File: rtl/bomb_countdown_timer_if.sv
// bomb_countdown_timer_if
// Groups the control pulses, load bus and display-facing outputs of the
// countdown timer.
//
// Handshake semantics: there is no valid/ready flow control on this block.
// start, defuse and load are single-cycle pulses sampled on the rising edge
// of clk; pause is a level. Outputs are registered or decoded from the state
// register, so a consumer may sample them on any edge.
//
// Signals:
//   start, pause, defuse, load  control inputs to the timer
//   load_ten[2:0], load_one[3:0] digit values captured by load
//   one[3:0], ten[2:0]           current BCD digits
//   bomb, running, defused       decoded state flags
//   dbg_state[1:0]               raw FSM state (IDLE=0, RUN=1, EXPLODED=2, DEFUSED=3)
interface bomb_countdown_timer_if;
    logic       start;
    logic       pause;
    logic       defuse;
    logic       load;
    logic [2:0] load_ten;
    logic [3:0] load_one;
    logic [3:0] one;
    logic [2:0] ten;
    logic       bomb;
    logic       running;
    logic       defused;
    logic [1:0] dbg_state;

    modport master (
        output start, pause, defuse, load, load_ten, load_one,
        input  one, ten, bomb, running, defused, dbg_state
    );

    modport slave (
        input  start, pause, defuse, load, load_ten, load_one,
        output one, ten, bomb, running, defused, dbg_state
    );
endinterface

// File: rtl/bomb_countdown_timer.sv
// bomb_countdown_timer
// Two-digit BCD countdown (tens 0-5, units 0-9) with a cycle prescaler that
// turns TICK_DIV clock cycles into one countdown step. Reaching 00 raises
// bomb; a defuse pulse freezes the count first.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  bomb_countdown_timer_if.slave (controls in, digits/flags out)
module bomb_countdown_timer #(
    parameter int TICK_DIV  = 1000,
    parameter int START_TEN = 5,
    parameter int START_ONE = 9
) (
    input logic                   clk,
    input logic                   rst,
    bomb_countdown_timer_if.slave bus
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        EXPLODED = 2'd2,
        DEFUSED  = 2'd3
    } state_t;

    state_t        state_q, state_n;
    logic [2:0]    ten_q, ten_n;
    logic [3:0]    one_q, one_n;
    logic [PW-1:0] presc_q, presc_n;

    logic [2:0] sat_ten;
    logic [3:0] sat_one;
    logic [2:0] dec_ten;
    logic [3:0] dec_one;

    // Loaded values are clamped so digits can never leave the BCD range.
    assign sat_ten = (bus.load_ten > 3'd5) ? 3'd5 : bus.load_ten;
    assign sat_one = (bus.load_one > 4'd9) ? 4'd9 : bus.load_one;

    // One countdown step with units borrow. Only used while the digits are
    // non-zero (RUN is never entered or kept at 00), so ten never underflows.
    always_comb begin
        dec_ten = ten_q;
        dec_one = one_q;
        if (one_q != 4'd0) begin
            dec_one = one_q - 4'd1;
        end else begin
            dec_one = 4'd9;
            dec_ten = ten_q - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ten_q   <= 3'(START_TEN);
            one_q   <= 4'(START_ONE);
            presc_q <= '0;
        end else begin
            state_q <= state_n;
            ten_q   <= ten_n;
            one_q   <= one_n;
            presc_q <= presc_n;
        end
    end

    always_comb begin
        state_n = state_q;
        ten_n   = ten_q;
        one_n   = one_q;
        presc_n = presc_q;
        case (state_q)
            IDLE: begin
                // load wins over a simultaneous start
                if (bus.load) begin
                    ten_n = sat_ten;
                    one_n = sat_one;
                end else if (bus.start) begin
                    presc_n = '0;
                    if (ten_q == 3'd0 && one_q == 4'd0) begin
                        state_n = EXPLODED;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                // defuse takes priority over a terminal tick in the same cycle
                if (bus.defuse) begin
                    state_n = DEFUSED;
                end else if (!bus.pause) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_n = '0;
                        ten_n   = dec_ten;
                        one_n   = dec_one;
                        if (dec_ten == 3'd0 && dec_one == 4'd0) begin
                            state_n = EXPLODED;
                        end
                    end else begin
                        presc_n = presc_q + PW'(1);
                    end
                end
            end
            EXPLODED, DEFUSED: begin
                if (bus.load) begin
                    ten_n   = sat_ten;
                    one_n   = sat_one;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.one       = one_q;
    assign bus.ten       = ten_q;
    assign bus.bomb      = (state_q == EXPLODED);
    assign bus.running   = (state_q == RUN);
    assign bus.defused   = (state_q == DEFUSED);
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_bomb_countdown_timer.sv
// tb_bomb_countdown_timer
// Directed bench for bomb_countdown_timer with TICK_DIV=4. Inputs are driven
// 1 time unit after a rising edge; outputs are sampled in the same phase.
// Observed outputs are packed as {ten, one, bomb, running, defused}.
module tb_bomb_countdown_timer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    bomb_countdown_timer_if bus ();

    bomb_countdown_timer #(
        .TICK_DIV (4),
        .START_TEN(5),
        .START_ONE(9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [9:0] obs;
    assign obs = {bus.ten, bus.one, bus.bomb, bus.running, bus.defused};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [2:0] t, input logic [3:0] o);
        bus.load_ten = t;
        bus.load_one = o;
        bus.load     = 1'b1;
        tick(1);
        bus.load     = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== {3'd5, 4'd9, 3'b000} || bus.dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL reset: got %h/%0d expected %h/0", obs, bus.dbg_state, {3'd5, 4'd9, 3'b000});
        end
        @(negedge clk);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_countdown();
        do_start();
        n_cmp++;
        if (obs !== {3'd5, 4'd9, 3'b010}) begin
            n_err++;
            $display("FAIL run_entry: got %h expected %h", obs, {3'd5, 4'd9, 3'b010});
        end
        tick(3);
        n_cmp++;
        if (obs !== {3'd5, 4'd9, 3'b010}) begin
            n_err++;
            $display("FAIL first_period_early: got %h expected %h", obs, {3'd5, 4'd9, 3'b010});
        end
        tick(1);
        n_cmp++;
        if (obs !== {3'd5, 4'd8, 3'b010}) begin
            n_err++;
            $display("FAIL first_decrement: got %h expected %h", obs, {3'd5, 4'd8, 3'b010});
        end
        tick(32);
        n_cmp++;
        if (obs !== {3'd5, 4'd0, 3'b010}) begin
            n_err++;
            $display("FAIL reach_50: got %h expected %h", obs, {3'd5, 4'd0, 3'b010});
        end
        tick(4);
        n_cmp++;
        if (obs !== {3'd4, 4'd9, 3'b010}) begin
            n_err++;
            $display("FAIL borrow_49: got %h expected %h", obs, {3'd4, 4'd9, 3'b010});
        end
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic test_explode();
        do_load(3'd0, 4'd2);
        n_cmp++;
        if (obs !== {3'd0, 4'd2, 3'b000}) begin
            n_err++;
            $display("FAIL load_02: got %h expected %h", obs, {3'd0, 4'd2, 3'b000});
        end
        do_start();
        tick(4);
        n_cmp++;
        if (obs !== {3'd0, 4'd1, 3'b010}) begin
            n_err++;
            $display("FAIL reach_01: got %h expected %h", obs, {3'd0, 4'd1, 3'b010});
        end
        tick(3);
        n_cmp++;
        if (obs !== {3'd0, 4'd1, 3'b010}) begin
            n_err++;
            $display("FAIL hold_01: got %h expected %h", obs, {3'd0, 4'd1, 3'b010});
        end
        tick(1);
        n_cmp++;
        if (obs !== {3'd0, 4'd0, 3'b100}) begin
            n_err++;
            $display("FAIL explode_00: got %h expected %h", obs, {3'd0, 4'd0, 3'b100});
        end
        bus.start  = 1'b1;
        bus.defuse = 1'b1;
        bus.pause  = 1'b1;
        tick(1);
        bus.start  = 1'b0;
        bus.defuse = 1'b0;
        bus.pause  = 1'b0;
        tick(2);
        n_cmp++;
        if (obs !== {3'd0, 4'd0, 3'b100}) begin
            n_err++;
            $display("FAIL exploded_sticky: got %h expected %h", obs, {3'd0, 4'd0, 3'b100});
        end
    endtask

    task automatic test_saturate();
        do_load(3'd7, 4'd12);
        n_cmp++;
        if (obs !== {3'd5, 4'd9, 3'b000}) begin
            n_err++;
            $display("FAIL load_saturate: got %h expected %h", obs, {3'd5, 4'd9, 3'b000});
        end
        do_load(3'd0, 4'd0);
        do_start();
        n_cmp++;
        if (obs !== {3'd0, 4'd0, 3'b100}) begin
            n_err++;
            $display("FAIL start_at_00: got %h expected %h", obs, {3'd0, 4'd0, 3'b100});
        end
        do_load(3'd2, 4'd2);
        bus.load_ten = 3'd1;
        bus.load_one = 4'd3;
        bus.load     = 1'b1;
        bus.start    = 1'b1;
        tick(1);
        bus.load     = 1'b0;
        bus.start    = 1'b0;
        n_cmp++;
        if (obs !== {3'd1, 4'd3, 3'b000}) begin
            n_err++;
            $display("FAIL load_over_start: got %h expected %h", obs, {3'd1, 4'd3, 3'b000});
        end
    endtask

    task automatic test_pause();
        do_load(3'd0, 4'd2);
        do_start();
        tick(4);
        tick(2);
        bus.pause = 1'b1;
        tick(10);
        n_cmp++;
        if (obs !== {3'd0, 4'd1, 3'b010}) begin
            n_err++;
            $display("FAIL pause_hold: got %h expected %h", obs, {3'd0, 4'd1, 3'b010});
        end
        bus.pause = 1'b0;
        tick(1);
        n_cmp++;
        if (obs !== {3'd0, 4'd1, 3'b010}) begin
            n_err++;
            $display("FAIL pause_resume: got %h expected %h", obs, {3'd0, 4'd1, 3'b010});
        end
        tick(1);
        n_cmp++;
        if (obs !== {3'd0, 4'd0, 3'b100}) begin
            n_err++;
            $display("FAIL pause_complete: got %h expected %h", obs, {3'd0, 4'd0, 3'b100});
        end
    endtask

    task automatic test_defuse();
        do_load(3'd0, 4'd2);
        do_start();
        tick(4);
        tick(3);
        bus.defuse = 1'b1;
        tick(1);
        bus.defuse = 1'b0;
        n_cmp++;
        if (obs !== {3'd0, 4'd1, 3'b001}) begin
            n_err++;
            $display("FAIL defuse_terminal: got %h expected %h", obs, {3'd0, 4'd1, 3'b001});
        end
        do_start();
        tick(5);
        n_cmp++;
        if (obs !== {3'd0, 4'd1, 3'b001}) begin
            n_err++;
            $display("FAIL defused_frozen: got %h expected %h", obs, {3'd0, 4'd1, 3'b001});
        end
        do_load(3'd3, 4'd0);
        n_cmp++;
        if (obs !== {3'd3, 4'd0, 3'b000}) begin
            n_err++;
            $display("FAIL defused_reload: got %h expected %h", obs, {3'd3, 4'd0, 3'b000});
        end
    endtask

    task automatic test_reset_mid();
        do_load(3'd4, 4'd3);
        do_start();
        tick(4);
        n_cmp++;
        if (obs !== {3'd4, 4'd2, 3'b010}) begin
            n_err++;
            $display("FAIL reach_42: got %h expected %h", obs, {3'd4, 4'd2, 3'b010});
        end
        tick(2);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== {3'd5, 4'd9, 3'b000}) begin
            n_err++;
            $display("FAIL async_reset: got %h expected %h", obs, {3'd5, 4'd9, 3'b000});
        end
        rst = 1'b0;
        tick(1);
        do_start();
        tick(3);
        n_cmp++;
        if (obs !== {3'd5, 4'd9, 3'b010}) begin
            n_err++;
            $display("FAIL post_reset_early: got %h expected %h", obs, {3'd5, 4'd9, 3'b010});
        end
        tick(1);
        n_cmp++;
        if (obs !== {3'd5, 4'd8, 3'b010}) begin
            n_err++;
            $display("FAIL post_reset_period: got %h expected %h", obs, {3'd5, 4'd8, 3'b010});
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.pause    = 1'b0;
        bus.defuse   = 1'b0;
        bus.load     = 1'b0;
        bus.load_ten = 3'd0;
        bus.load_one = 4'd0;
        test_reset();
        test_countdown();
        test_explode();
        test_saturate();
        test_pause();
        test_defuse();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
